// File: rtl/usc_rv_wb_pkg.sv
// Shared types and constants for the integer writeback arbiter.
// Optional feature macro used by the top: USC_RV_WB_PERF_EN (stall counter).
package usc_rv_wb_pkg;

  localparam int XLEN_DEF     = 64;
  localparam int ATAG_W_DEF   = 5;
  localparam int NUM_SLOW_SRC = 3;

  // Slow (handshaked) result sources, in round-robin scan order.
  typedef enum logic [1:0] {
    SRC_MC  = 2'd0,
    SRC_LD  = 2'd1,
    SRC_SYS = 2'd2
  } slow_src_e;

  // One result request at the default widths.
  typedef struct packed {
    logic                  vld;
    logic [ATAG_W_DEF-1:0] atag;
    logic [XLEN_DEF-1:0]   data;
  } wb_req_t;

  // Cyclic successor over the three slow sources (mc -> ld -> sys -> mc).
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'(SRC_SYS)) ? 2'(SRC_MC) : p + 2'd1;
  endfunction

endpackage

// File: rtl/usc_rv_wb_rr_sel.sv
// Three-requester round-robin picker granting up to two requesters per cycle.
// The scan starts at ptr; each grant gets a slot (0 = first free port,
// 1 = second free port). ptr_next is the source after the last grant,
// or ptr unchanged when nothing is granted.
module usc_rv_wb_rr_sel
  import usc_rv_wb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] num_free,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [2:0] slot,
  output logic [1:0] ptr_next
);

  logic [1:0] w_idx;
  logic [1:0] w_cnt;
  logic [1:0] w_last;

  // Cyclic scan from ptr, granting while free ports remain.
  always_comb begin
    gnt    = '0;
    slot   = '0;
    w_cnt  = '0;
    w_last = ptr;
    w_idx  = ptr;
    for (int i = 0; i < NUM_SLOW_SRC; i++) begin
      if (req[w_idx] && (w_cnt < num_free)) begin
        gnt[w_idx]  = 1'b1;
        slot[w_idx] = w_cnt[0];
        w_cnt       = w_cnt + 2'd1;
        w_last      = w_idx;
      end
      w_idx = rr_next(w_idx);
    end
    ptr_next = (|gnt) ? rr_next(w_last) : ptr;
  end

endmodule

// File: rtl/usc_rv_wb_arb.sv
// Writeback arbiter for the two integer register-file write ports.
// ALU0/ALU1 own ports 0/1; mc/ld/sys share leftover ports round-robin.
// A starvation monitor raises iss_alu_block_o so waiting slow results drain.
// Optional: define USC_RV_WB_PERF_EN to add the wb_stall_cnt_o counter.
module usc_rv_wb_arb
  import usc_rv_wb_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int ATAG_W     = ATAG_W_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu0_res_vld,
  input  logic [ATAG_W-1:0] alu0_res_atag,
  input  logic [XLEN-1:0]   alu0_res_data,
  input  logic              alu1_res_vld,
  input  logic [ATAG_W-1:0] alu1_res_atag,
  input  logic [XLEN-1:0]   alu1_res_data,
  input  logic              mc_res_vld,
  input  logic [ATAG_W-1:0] mc_res_atag,
  input  logic [XLEN-1:0]   mc_res_data,
  output logic              mc_res_rdy,
  input  logic              ld_res_vld,
  input  logic [ATAG_W-1:0] ld_res_atag,
  input  logic [XLEN-1:0]   ld_res_data,
  output logic              ld_res_rdy,
  input  logic              sys_res_vld,
  input  logic [ATAG_W-1:0] sys_res_atag,
  input  logic [XLEN-1:0]   sys_res_data,
  output logic              sys_res_rdy,
  output logic              iss_alu_block_o,
  output logic              rf_wr0_en,
  output logic [ATAG_W-1:0] rf_wr0_addr,
  output logic [XLEN-1:0]   rf_wr0_data,
  output logic              rf_wr1_en,
  output logic [ATAG_W-1:0] rf_wr1_addr,
  output logic [XLEN-1:0]   rf_wr1_data,
  output logic              wb_conflict_o
`ifdef USC_RV_WB_PERF_EN
  ,
  output logic [31:0]       wb_stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [NUM_SLOW_SRC-1:0] w_slow_vld;
  logic [ATAG_W-1:0]       w_slow_atag [NUM_SLOW_SRC];
  logic [XLEN-1:0]         w_slow_data [NUM_SLOW_SRC];
  logic [NUM_SLOW_SRC-1:0] w_gnt_raw;
  logic [NUM_SLOW_SRC-1:0] w_gnt;
  logic [NUM_SLOW_SRC-1:0] w_slot;
  logic [NUM_SLOW_SRC-1:0] w_at_max;
  logic [1:0]              w_num_free;
  logic [1:0]              w_rr_ptr_next;
  logic [1:0]              r_rr_ptr;

  logic                    w_p1_slot;
  logic                    w_p0_vld;
  logic [ATAG_W-1:0]       w_p0_atag;
  logic [XLEN-1:0]         w_p0_data;
  logic                    w_p1_vld;
  logic [ATAG_W-1:0]       w_p1_atag;
  logic [XLEN-1:0]         w_p1_data;
  logic                    w_en0;
  logic                    w_en1;
  logic                    w_conflict;

  logic                    r_wr0_en;
  logic [ATAG_W-1:0]       r_wr0_addr;
  logic [XLEN-1:0]         r_wr0_data;
  logic                    r_wr1_en;
  logic [ATAG_W-1:0]       r_wr1_addr;
  logic [XLEN-1:0]         r_wr1_data;
  logic                    r_conflict;
  logic                    r_block;

  assign w_slow_vld = {sys_res_vld, ld_res_vld, mc_res_vld};
  assign w_slow_atag[SRC_MC]  = mc_res_atag;
  assign w_slow_atag[SRC_LD]  = ld_res_atag;
  assign w_slow_atag[SRC_SYS] = sys_res_atag;
  assign w_slow_data[SRC_MC]  = mc_res_data;
  assign w_slow_data[SRC_LD]  = ld_res_data;
  assign w_slow_data[SRC_SYS] = sys_res_data;

  // Ports not claimed by a valid ALU result are available to slow sources.
  assign w_num_free = {1'b0, ~alu0_res_vld} + {1'b0, ~alu1_res_vld};

  usc_rv_wb_rr_sel u_rr_sel (
    .req      (w_slow_vld),
    .num_free (w_num_free),
    .ptr      (r_rr_ptr),
    .gnt      (w_gnt_raw),
    .slot     (w_slot),
    .ptr_next (w_rr_ptr_next)
  );

  // Grants are suppressed while reset is held so no handshake completes.
  assign w_gnt       = w_gnt_raw & {NUM_SLOW_SRC{reset_n}};
  assign mc_res_rdy  = w_gnt[SRC_MC];
  assign ld_res_rdy  = w_gnt[SRC_LD];
  assign sys_res_rdy = w_gnt[SRC_SYS];

  // Round-robin pointer update after any slow grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rr_ptr <= 2'(SRC_MC);
    else          r_rr_ptr <= w_rr_ptr_next;
  end

  // Steer ALU results and slot-ordered slow grants onto the two ports.
  always_comb begin
    w_p0_vld  = 1'b0;
    w_p0_atag = '0;
    w_p0_data = '0;
    w_p1_vld  = 1'b0;
    w_p1_atag = '0;
    w_p1_data = '0;
    // Port 1 takes the first slow grant when ALU0 holds port 0.
    w_p1_slot = ~alu0_res_vld;
    if (alu0_res_vld) begin
      w_p0_vld  = 1'b1;
      w_p0_atag = alu0_res_atag;
      w_p0_data = alu0_res_data;
    end else begin
      for (int s = 0; s < NUM_SLOW_SRC; s++) begin
        if (w_gnt[s] && !w_slot[s]) begin
          w_p0_vld  = 1'b1;
          w_p0_atag = w_slow_atag[s];
          w_p0_data = w_slow_data[s];
        end
      end
    end
    if (alu1_res_vld) begin
      w_p1_vld  = 1'b1;
      w_p1_atag = alu1_res_atag;
      w_p1_data = alu1_res_data;
    end else begin
      for (int s = 0; s < NUM_SLOW_SRC; s++) begin
        if (w_gnt[s] && (w_slot[s] == w_p1_slot)) begin
          w_p1_vld  = 1'b1;
          w_p1_atag = w_slow_atag[s];
          w_p1_data = w_slow_data[s];
        end
      end
    end
  end

  // Tag 0 is consumed but never written; equal nonzero tags let port 1 win.
  assign w_en0      = w_p0_vld && (w_p0_atag != '0);
  assign w_en1      = w_p1_vld && (w_p1_atag != '0);
  assign w_conflict = w_en0 && w_en1 && (w_p0_atag == w_p1_atag);

  // Register the write ports one cycle after selection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr0_en   <= 1'b0;
      r_wr0_addr <= '0;
      r_wr0_data <= '0;
      r_wr1_en   <= 1'b0;
      r_wr1_addr <= '0;
      r_wr1_data <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_wr0_en   <= w_en0 && !w_conflict;
      r_wr0_addr <= w_p0_atag;
      r_wr0_data <= w_p0_data;
      r_wr1_en   <= w_en1;
      r_wr1_addr <= w_p1_atag;
      r_wr1_data <= w_p1_data;
      r_conflict <= w_conflict;
    end
  end

  // Per-source wait counters, saturating at STARVE_MAX.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOW_SRC; gi++) begin : g_starve
      logic [CNT_W-1:0] r_cnt;

      // Count waiting cycles; clear when granted or idle.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         r_cnt <= '0;
        else if (!w_slow_vld[gi] || w_gnt[gi]) r_cnt <= '0;
        else if (r_cnt != CNT_W'(STARVE_MAX)) r_cnt <= r_cnt + 1'b1;
      end

      assign w_at_max[gi] = (r_cnt == CNT_W'(STARVE_MAX));
    end
  endgenerate

  // Block ALU issue the cycle after any source has waited STARVE_MAX cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_block <= 1'b0;
    else          r_block <= |w_at_max;
  end

`ifdef USC_RV_WB_PERF_EN
  logic [31:0] r_stall_cnt;

  // Count cycles where some slow source waits without a grant (wrapping).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stall_cnt <= '0;
    else          r_stall_cnt <= r_stall_cnt + 32'(|(w_slow_vld & ~w_gnt));
  end

  assign wb_stall_cnt_o = r_stall_cnt;
`endif

  assign rf_wr0_en       = r_wr0_en;
  assign rf_wr0_addr     = r_wr0_addr;
  assign rf_wr0_data     = r_wr0_data;
  assign rf_wr1_en       = r_wr1_en;
  assign rf_wr1_addr     = r_wr1_addr;
  assign rf_wr1_data     = r_wr1_data;
  assign wb_conflict_o   = r_conflict;
  assign iss_alu_block_o = r_block;

endmodule

// File: tb/tb_usc_rv_wb_arb.sv
// Directed self-checking bench for usc_rv_wb_arb (STARVE_MAX = 4).
module tb_usc_rv_wb_arb;

  localparam int XLEN   = 64;
  localparam int ATAG_W = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              alu0_res_vld, alu1_res_vld;
  logic [ATAG_W-1:0] alu0_res_atag, alu1_res_atag;
  logic [XLEN-1:0]   alu0_res_data, alu1_res_data;
  logic              mc_res_vld, ld_res_vld, sys_res_vld;
  logic [ATAG_W-1:0] mc_res_atag, ld_res_atag, sys_res_atag;
  logic [XLEN-1:0]   mc_res_data, ld_res_data, sys_res_data;
  logic              mc_res_rdy, ld_res_rdy, sys_res_rdy;
  logic              iss_alu_block_o;
  logic              rf_wr0_en, rf_wr1_en;
  logic [ATAG_W-1:0] rf_wr0_addr, rf_wr1_addr;
  logic [XLEN-1:0]   rf_wr0_data, rf_wr1_data;
  logic              wb_conflict_o;
`ifdef USC_RV_WB_PERF_EN
  logic [31:0]       wb_stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usc_rv_wb_arb #(.XLEN(XLEN), .ATAG_W(ATAG_W), .STARVE_MAX(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .alu0_res_vld    (alu0_res_vld),
    .alu0_res_atag   (alu0_res_atag),
    .alu0_res_data   (alu0_res_data),
    .alu1_res_vld    (alu1_res_vld),
    .alu1_res_atag   (alu1_res_atag),
    .alu1_res_data   (alu1_res_data),
    .mc_res_vld      (mc_res_vld),
    .mc_res_atag     (mc_res_atag),
    .mc_res_data     (mc_res_data),
    .mc_res_rdy      (mc_res_rdy),
    .ld_res_vld      (ld_res_vld),
    .ld_res_atag     (ld_res_atag),
    .ld_res_data     (ld_res_data),
    .ld_res_rdy      (ld_res_rdy),
    .sys_res_vld     (sys_res_vld),
    .sys_res_atag    (sys_res_atag),
    .sys_res_data    (sys_res_data),
    .sys_res_rdy     (sys_res_rdy),
    .iss_alu_block_o (iss_alu_block_o),
    .rf_wr0_en       (rf_wr0_en),
    .rf_wr0_addr     (rf_wr0_addr),
    .rf_wr0_data     (rf_wr0_data),
    .rf_wr1_en       (rf_wr1_en),
    .rf_wr1_addr     (rf_wr1_addr),
    .rf_wr1_data     (rf_wr1_data),
    .wb_conflict_o   (wb_conflict_o)
`ifdef USC_RV_WB_PERF_EN
    ,
    .wb_stall_cnt_o  (wb_stall_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu0_res_vld = 0; alu0_res_atag = '0; alu0_res_data = '0;
    alu1_res_vld = 0; alu1_res_atag = '0; alu1_res_data = '0;
    mc_res_vld = 0;  mc_res_atag = '0;  mc_res_data = '0;
    ld_res_vld = 0;  ld_res_atag = '0;  ld_res_data = '0;
    sys_res_vld = 0; sys_res_atag = '0; sys_res_data = '0;
  endtask

  // Packs every output into one vector; zero means all outputs low.
  function automatic logic [159:0] all_outs();
    return {mc_res_rdy, ld_res_rdy, sys_res_rdy, iss_alu_block_o, wb_conflict_o,
            rf_wr0_en, rf_wr0_addr, rf_wr0_data, rf_wr1_en, rf_wr1_addr, rf_wr1_data};
  endfunction

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    #7;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", all_outs());
    end
    $display("[%0t] reset asserted, outputs sampled", $time);
    tick();
    reset_n = 1;
  endtask

  task automatic test_alu_ports();
    alu0_res_vld = 1; alu0_res_atag = 5'd3; alu0_res_data = 64'h11;
    alu1_res_vld = 1; alu1_res_atag = 5'd4; alu1_res_data = 64'h22;
    mc_res_vld = 1;   mc_res_atag = 5'd9;   mc_res_data = 64'h99;
    #1;
    checks++;
    if (mc_res_rdy !== 1'b0) begin
      errors++; $display("FAIL alu_mc_rdy: got %b required 0", mc_res_rdy);
    end
    tick();
    clear_inputs();
    $display("[%0t] alu ports: wr0=%b/%0d/%h wr1=%b/%0d/%h", $time,
             rf_wr0_en, rf_wr0_addr, rf_wr0_data, rf_wr1_en, rf_wr1_addr, rf_wr1_data);
    checks++;
    if ({rf_wr0_en, rf_wr0_addr, rf_wr0_data} !== {1'b1, 5'd3, 64'h11}) begin
      errors++; $display("FAIL alu_wr0: got %b/%0d/%h required 1/3/11", rf_wr0_en, rf_wr0_addr, rf_wr0_data);
    end
    checks++;
    if ({rf_wr1_en, rf_wr1_addr, rf_wr1_data} !== {1'b1, 5'd4, 64'h22}) begin
      errors++; $display("FAIL alu_wr1: got %b/%0d/%h required 1/4/22", rf_wr1_en, rf_wr1_addr, rf_wr1_data);
    end
  endtask

  task automatic test_round_robin();
    mc_res_vld = 1;  mc_res_atag = 5'd1;  mc_res_data = 64'hA1;
    ld_res_vld = 1;  ld_res_atag = 5'd2;  ld_res_data = 64'hA2;
    sys_res_vld = 1; sys_res_atag = 5'd6; sys_res_data = 64'hA3;
    #1;
    checks++;
    if ({mc_res_rdy, ld_res_rdy, sys_res_rdy} !== 3'b110) begin
      errors++; $display("FAIL rr_cycle0_rdy: got %b%b%b required 110", mc_res_rdy, ld_res_rdy, sys_res_rdy);
    end
    tick();
    $display("[%0t] rr cycle0: wr0=%0d wr1=%0d", $time, rf_wr0_addr, rf_wr1_addr);
    checks++;
    if ({rf_wr0_en, rf_wr0_addr, rf_wr0_data, rf_wr1_en, rf_wr1_addr, rf_wr1_data}
        !== {1'b1, 5'd1, 64'hA1, 1'b1, 5'd2, 64'hA2}) begin
      errors++; $display("FAIL rr_cycle0_wr: got %b/%0d %b/%0d required 1/1 1/2", rf_wr0_en, rf_wr0_addr, rf_wr1_en, rf_wr1_addr);
    end
    mc_res_vld = 0; ld_res_vld = 0;
    #1;
    checks++;
    if (sys_res_rdy !== 1'b1) begin
      errors++; $display("FAIL rr_cycle1_sys_rdy: got %b required 1", sys_res_rdy);
    end
    tick();
    sys_res_vld = 0;
    $display("[%0t] rr cycle1: wr0=%0d en1=%b", $time, rf_wr0_addr, rf_wr1_en);
    checks++;
    if ({rf_wr0_en, rf_wr0_addr, rf_wr0_data, rf_wr1_en} !== {1'b1, 5'd6, 64'hA3, 1'b0}) begin
      errors++; $display("FAIL rr_cycle1_wr: got %b/%0d/%h en1=%b required 1/6/a3 en1=0", rf_wr0_en, rf_wr0_addr, rf_wr0_data, rf_wr1_en);
    end
    // Pointer must be back at mc: one free port, mc and ld both waiting.
    alu0_res_vld = 1; alu0_res_atag = 5'd8; alu0_res_data = 64'h80;
    mc_res_vld = 1;  mc_res_atag = 5'd12; mc_res_data = 64'hB1;
    ld_res_vld = 1;  ld_res_atag = 5'd13; ld_res_data = 64'hB2;
    #1;
    checks++;
    if ({mc_res_rdy, ld_res_rdy} !== 2'b10) begin
      errors++; $display("FAIL rr_ptr_mc: got mc=%b ld=%b required mc=1 ld=0", mc_res_rdy, ld_res_rdy);
    end
    tick();
    clear_inputs();
    $display("[%0t] rr ptr check: wr1=%0d", $time, rf_wr1_addr);
    checks++;
    if ({rf_wr1_en, rf_wr1_addr, rf_wr1_data} !== {1'b1, 5'd12, 64'hB1}) begin
      errors++; $display("FAIL rr_ptr_wr1: got %b/%0d/%h required 1/12/b1", rf_wr1_en, rf_wr1_addr, rf_wr1_data);
    end
  endtask

  task automatic test_tag_zero();
    alu1_res_vld = 1; alu1_res_atag = 5'd5; alu1_res_data = 64'h55;
    ld_res_vld = 1;   ld_res_atag = 5'd0;   ld_res_data = 64'hDEAD;
    #1;
    checks++;
    if ({ld_res_rdy, mc_res_rdy} !== 2'b10) begin
      errors++; $display("FAIL tag0_rdy: got ld=%b mc=%b required ld=1 mc=0", ld_res_rdy, mc_res_rdy);
    end
    tick();
    clear_inputs();
    $display("[%0t] tag0: en0=%b wr1=%b/%0d", $time, rf_wr0_en, rf_wr1_en, rf_wr1_addr);
    checks++;
    if ({rf_wr0_en, rf_wr1_en, rf_wr1_addr, rf_wr1_data} !== {1'b0, 1'b1, 5'd5, 64'h55}) begin
      errors++; $display("FAIL tag0_wr: got en0=%b wr1=%b/%0d/%h required en0=0 wr1=1/5/55", rf_wr0_en, rf_wr1_en, rf_wr1_addr, rf_wr1_data);
    end
  endtask

  task automatic test_conflict();
    alu0_res_vld = 1; alu0_res_atag = 5'd7; alu0_res_data = 64'h70;
    alu1_res_vld = 1; alu1_res_atag = 5'd7; alu1_res_data = 64'h71;
    tick();
    clear_inputs();
    $display("[%0t] conflict: en0=%b en1=%b conf=%b", $time, rf_wr0_en, rf_wr1_en, wb_conflict_o);
    checks++;
    if ({rf_wr0_en, rf_wr1_en, rf_wr1_addr, rf_wr1_data, wb_conflict_o} !== {1'b0, 1'b1, 5'd7, 64'h71, 1'b1}) begin
      errors++; $display("FAIL conflict: got en0=%b wr1=%b/%0d/%h conf=%b required 0 1/7/71 1", rf_wr0_en, rf_wr1_en, rf_wr1_addr, rf_wr1_data, wb_conflict_o);
    end
    tick();
    checks++;
    if (wb_conflict_o !== 1'b0) begin
      errors++; $display("FAIL conflict_pulse: got %b required 0", wb_conflict_o);
    end
  endtask

  task automatic test_starvation();
    alu0_res_vld = 1; alu0_res_atag = 5'd10; alu0_res_data = 64'h10;
    alu1_res_vld = 1; alu1_res_atag = 5'd11; alu1_res_data = 64'h11;
    ld_res_vld = 1;   ld_res_atag = 5'd12;   ld_res_data = 64'hC;
    for (int k = 1; k <= 6; k++) begin
      tick();
      $display("[%0t] starve edge %0d: block=%b ld_rdy=%b", $time, k, iss_alu_block_o, ld_res_rdy);
      checks++;
      if ({iss_alu_block_o, ld_res_rdy} !== {(k >= 5), 1'b0}) begin
        errors++; $display("FAIL starve_block_e%0d: got block=%b rdy=%b required block=%b rdy=0", k, iss_alu_block_o, ld_res_rdy, (k >= 5));
      end
    end
    alu0_res_vld = 0; alu1_res_vld = 0;
    #1;
    checks++;
    if (ld_res_rdy !== 1'b1) begin
      errors++; $display("FAIL starve_drain_rdy: got %b required 1", ld_res_rdy);
    end
    tick();
    ld_res_vld = 0;
    $display("[%0t] starve drain: wr0=%0d block=%b", $time, rf_wr0_addr, iss_alu_block_o);
    checks++;
    if ({rf_wr0_en, rf_wr0_addr, rf_wr0_data, iss_alu_block_o} !== {1'b1, 5'd12, 64'hC, 1'b1}) begin
      errors++; $display("FAIL starve_drain_wr: got %b/%0d/%h block=%b required 1/12/c block=1", rf_wr0_en, rf_wr0_addr, rf_wr0_data, iss_alu_block_o);
    end
    tick();
    checks++;
    if (iss_alu_block_o !== 1'b0) begin
      errors++; $display("FAIL starve_block_fall: got %b required 0", iss_alu_block_o);
    end
  endtask

  task automatic test_reset_mid_op();
    alu0_res_vld = 1; alu0_res_atag = 5'd14; alu0_res_data = 64'hE0;
    alu1_res_vld = 1; alu1_res_atag = 5'd15; alu1_res_data = 64'hF0;
    mc_res_vld = 1;   mc_res_atag = 5'd16;   mc_res_data = 64'h16;
    ld_res_vld = 1;   ld_res_atag = 5'd17;   ld_res_data = 64'h17;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if ({iss_alu_block_o, rf_wr0_en} !== 2'b11) begin
      errors++; $display("FAIL midrst_pre: got block=%b en0=%b required 1 1", iss_alu_block_o, rf_wr0_en);
    end
    #2;
    reset_n = 0;
    #1;
    $display("[%0t] reset dropped mid-cycle: outs=%h", $time, all_outs());
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL midrst_outputs: got %h required 0", all_outs());
    end
    tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL midrst_held: got %h required 0", all_outs());
    end
    reset_n = 1;
    alu1_res_vld = 0;
    sys_res_vld = 1; sys_res_atag = 5'd18; sys_res_data = 64'h18;
    #1;
    checks++;
    if ({mc_res_rdy, ld_res_rdy, sys_res_rdy} !== 3'b100) begin
      errors++; $display("FAIL midrst_first_gnt: got %b%b%b required 100", mc_res_rdy, ld_res_rdy, sys_res_rdy);
    end
    tick();
    clear_inputs();
    $display("[%0t] after reset: wr0=%0d wr1=%0d block=%b", $time, rf_wr0_addr, rf_wr1_addr, iss_alu_block_o);
    checks++;
    if ({rf_wr0_en, rf_wr0_addr, rf_wr1_en, rf_wr1_addr, rf_wr1_data, iss_alu_block_o}
        !== {1'b1, 5'd14, 1'b1, 5'd16, 64'h16, 1'b0}) begin
      errors++; $display("FAIL midrst_wr: got %b/%0d %b/%0d/%h block=%b required 1/14 1/16/16 0", rf_wr0_en, rf_wr0_addr, rf_wr1_en, rf_wr1_addr, rf_wr1_data, iss_alu_block_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ports();
    test_round_robin();
    test_tag_zero();
    test_conflict();
    test_starvation();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
